spi_xfer_arb: RTL

SPI_XFER_ARB -- requirements
Module: spi_xfer_arb

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_rr_arb2.sv | 17 +
 rtl/spi_xfer_arb.sv | 120 ++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: transfer-arbiter state encoding, data/counter widths
// and the CPU-visible SPI register indices.
package spi_pkg;

  localparam int SPI_W_DATA    = 32;
  localparam int SPI_TMO_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } xfer_state_t;

  // Coprocessor register indices used by the CPU MTC0/MFC0 path.
  localparam logic [4:0] SPI_REG_CTRL   = 5'd0;
  localparam logic [4:0] SPI_REG_STATUS = 5'd1;
  localparam logic [4:0] SPI_REG_TXDATA = 5'd2;
  localparam logic [4:0] SPI_REG_RXDATA = 5'd3;
  localparam logic [4:0] SPI_REG_CLKDIV = 5'd4;

endpackage

// File: rtl/spi_rr_arb2.sv
// Two-way round-robin selector: on contention, the requester not served last wins.
module spi_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/spi_xfer_arb.sv
// Arbitrates two requesters onto one SPI word engine, one word per grant.
// Define SPI_XFER_ARB_TIMEOUT_EN to bound the WAIT state by TIMEOUT cycles.
module spi_xfer_arb
  import spi_pkg::*;
#(
  parameter int W_DATA  = SPI_W_DATA,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [W_DATA-1:0] wdata0,
  output logic [W_DATA-1:0] rdata0,
  output logic              done0,
  input  logic              req1,
  input  logic [W_DATA-1:0] wdata1,
  output logic [W_DATA-1:0] rdata1,
  output logic              done1,
  output logic [1:0]        grant,
  input  logic              spi_tx_ready,
  output logic              spi_tx_dv,
  output logic [W_DATA-1:0] spi_tx_data,
  input  logic              spi_rx_dv,
  input  logic [W_DATA-1:0] spi_rx_data,
  output logic              err
);

  xfer_state_t state;
  logic        last;
  logic [1:0]  arb_gnt;

  // TIMEOUT must fit the shared counter whether or not the timeout is built in.
  if (TIMEOUT < 1 || TIMEOUT >= (1 << SPI_TMO_CNT_W)) begin : g_bad_timeout
    $error("spi_xfer_arb: TIMEOUT out of range for the timeout counter");
  end

  spi_rr_arb2 u_rr (
    .req  ({req1, req0}),
    .last (last),
    .gnt  (arb_gnt)
  );

`ifdef SPI_XFER_ARB_TIMEOUT_EN
  localparam logic [SPI_TMO_CNT_W-1:0] TMO_LAST = SPI_TMO_CNT_W'(TIMEOUT - 1);
  logic [SPI_TMO_CNT_W-1:0] tmo_cnt;
`else
  assign err = 1'b0;
`endif

  // Strobes (tx_dv, done, err) default low each cycle so they are single pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant       <= 2'b00;
      last        <= 1'b1;
      spi_tx_dv   <= 1'b0;
      spi_tx_data <= '0;
      rdata0      <= '0;
      rdata1      <= '0;
      done0       <= 1'b0;
      done1       <= 1'b0;
`ifdef SPI_XFER_ARB_TIMEOUT_EN
      err         <= 1'b0;
      tmo_cnt     <= '0;
`endif
    end else begin
      spi_tx_dv   <= 1'b0;
      spi_tx_data <= '0;
      done0       <= 1'b0;
      done1       <= 1'b0;
`ifdef SPI_XFER_ARB_TIMEOUT_EN
      err         <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (spi_tx_ready && (req0 || req1)) begin
            grant       <= arb_gnt;
            spi_tx_dv   <= 1'b1;
            spi_tx_data <= arb_gnt[1] ? wdata1 : wdata0;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
`ifdef SPI_XFER_ARB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          if (spi_rx_dv) begin
            if (grant[1]) rdata1 <= spi_rx_data;
            else          rdata0 <= spi_rx_data;
            done0 <= grant[0];
            done1 <= grant[1];
            state <= ST_DONE;
          end
`ifdef SPI_XFER_ARB_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            if (grant[1]) rdata1 <= '1;
            else          rdata0 <= '1;
            done0 <= grant[0];
            done1 <= grant[1];
            err   <= 1'b1;
            state <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          last  <= grant[1];
          grant <= 2'b00;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
